arinc_txrx_loop: RTL and testbench

// - ARINC-429-style serial link test block: a transmitter frames {ADR, DAT, parity} into a 32-bit bipolar RZ word.
// - A receiver decodes the TXD1/TXD0 loopback and rebuilds the address and data.
// - Sits between a word source (ADR/DAT/st) and a consumer of received words (ce_wr strobe); all debug nets are exported.

---
 rtl/arinc_txrx_loop_pkg.sv | 38 +++
 rtl/arinc_txrx_loop_rx.sv | 98 +++++++++
 rtl/arinc_txrx_loop.sv | 151 +++++++++++++++
 tb/tb_arinc_txrx_loop.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arinc_txrx_loop_pkg.sv
// Shared constants and helpers for the ARINC-429-style loopback block:
// rate table, word/field geometry and frame bit ordering.
package arinc_txrx_loop_pkg;

  localparam int WORD_BITS    = 32;
  localparam int GAP_BITS_DEF = 4;
  localparam int ADR_W        = 8;
  localparam int DAT_W        = 23;
  localparam int DIV_W        = 16;

  // Bit rate in bit/s, indexed by Nvel.
  localparam int RATE_HZ [4] = '{12_500, 50_000, 100_000, 100_000};

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

  // clk cycles per half-bit; ce_tx runs at twice the bit rate.
  function automatic logic [DIV_W-1:0] half_div(input int f_clk, input logic [1:0] nvel);
    return DIV_W'(f_clk / (2 * RATE_HZ[nvel]));
  endfunction

  function automatic logic [ADR_W-1:0] rev8(input logic [ADR_W-1:0] v);
    logic [ADR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADR_W; i++) r[i] = v[ADR_W-1-i];
    return r;
  endfunction

  // Line order of bits 1..31: ADR MSB first, then DAT LSB first; index 0 goes out first.
  function automatic logic [WORD_BITS-2:0] tx_frame(input logic [ADR_W-1:0] adr,
                                                    input logic [DAT_W-1:0] dat);
    return {dat, rev8(adr)};
  endfunction

endpackage

// File: rtl/arinc_txrx_loop_rx.sv
// Self-clocked line decoder: one bit per rising edge of TXD1|TXD0, rebuilds
// ADR/DAT after 32 bits, checks odd parity and drops partial words on idle.
module arinc_rx
  import arinc_txrx_loop_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   txd1_i,
  input  logic                   txd0_i,
  input  logic [DIV_W-1:0]       half_i,
  output logic [ADR_W-1:0]       adr_o,
  output logic [DAT_W-1:0]       dat_o,
  output logic [4:0]             cb_o,
  output logic                   wr_o,
  output logic                   par_ok_o,
  output logic                   res_o
);

  localparam logic [4:0] LAST_BIT = 5'(WORD_BITS - 1);

  logic                 line_q, line_d;
  logic [WORD_BITS-1:0] sr_q, sr_d;
  logic [4:0]           cb_q, cb_d;
  logic [DIV_W+1:0]     idle_q, idle_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [DAT_W-1:0]     dat_q, dat_d;
  logic                 ok_q, ok_d;
  logic                 wr_q, wr_d;
  logic                 res_q, res_d;
  logic                 rise;

  assign rise = (txd1_i | txd0_i) & ~line_q;

  always_comb begin
    line_d = txd1_i | txd0_i;
    sr_d   = sr_q;
    cb_d   = cb_q;
    idle_d = idle_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    ok_d   = ok_q;
    wr_d   = 1'b0;
    res_d  = 1'b0;
    if (rise) begin
      sr_d[cb_q] = txd1_i;
      // Timeout window is two bit-times (four half-bits) from the last edge.
      idle_d = {half_i, 2'b00};
      if (cb_q == LAST_BIT) begin
        adr_d = rev8(sr_d[ADR_W-1:0]);
        dat_d = sr_d[WORD_BITS-2:ADR_W];
        ok_d  = ^sr_d;
        wr_d  = 1'b1;
        cb_d  = '0;
      end else begin
        cb_d = cb_q + 5'd1;
      end
    end else if (cb_q != '0) begin
      if (idle_q == '0) begin
        res_d = 1'b1;
        cb_d  = '0;
      end else begin
        idle_d = idle_q - (DIV_W+2)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      line_q <= 1'b0;
      sr_q   <= '0;
      cb_q   <= '0;
      idle_q <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      ok_q   <= 1'b0;
      wr_q   <= 1'b0;
      res_q  <= 1'b0;
    end else begin
      line_q <= line_d;
      sr_q   <= sr_d;
      cb_q   <= cb_d;
      idle_q <= idle_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      ok_q   <= ok_d;
      wr_q   <= wr_d;
      res_q  <= res_d;
    end
  end

  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign cb_o     = cb_q;
  assign wr_o     = wr_q;
  assign par_ok_o = ok_q;
  assign res_o    = res_q;

endmodule

// File: rtl/arinc_txrx_loop.sv
// ARINC-429-style transmitter with bipolar RZ line driver, looped back into
// the arinc_rx decoder.
//   state   | meaning
//   TX_IDLE | waiting for st; line quiet
//   TX_DATA | 32 word bits on the line (cb_bit_tx 0..31)
//   TX_GAP  | idle bit-times after the word (cb_bit_tx 32..35)
module arinc_txrx_loop
  import arinc_txrx_loop_pkg::*;
#(
  parameter int F_CLK    = 50_000_000,
  parameter int GAP_BITS = GAP_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Nvel,
  input  logic [7:0]  ADR,
  input  logic [22:0] DAT,
  input  logic        st,
  output logic        ce_tx,
  output logic        FT_tx,
  output logic        en_tx_word,
  output logic        en_tx_dat,
  output logic [5:0]  cb_bit_tx,
  output logic        SDAT,
  output logic        T_cp_tx,
  output logic        QM,
  output logic        TXD1,
  output logic        TXD0,
  output logic        SLP,
  output logic [7:0]  sr_adr_rx,
  output logic [22:0] sr_dat_rx,
  output logic [4:0]  cb_bit_rx,
  output logic        ce_wr,
  output logic        FT_cp_rx,
  output logic        res
);

  localparam logic [5:0] LAST_DAT = 6'(WORD_BITS - 1);
  localparam logic [5:0] LAST_BIT = 6'(WORD_BITS + GAP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       half_q, half_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   ft_q, ft_d;
  logic [5:0]             cb_q, cb_d;
  logic [WORD_BITS-2:0]   sr_q, sr_d;
  logic                   par_q, par_d;
  logic                   slp_q, slp_d;
  logic [DIV_W-1:0]       half_new;
  logic                   busy, bit_end, sdat;

  assign half_new = half_div(F_CLK, Nvel);
  assign busy     = (state_q != TX_IDLE);
  assign ce_tx    = busy && (div_q == '0);
  assign bit_end  = ce_tx && !ft_q;
  // The parity bit is the running accumulator itself, so bit 32 closes the word odd.
  assign sdat     = (state_q == TX_DATA) && ((cb_q == LAST_DAT) ? par_q : sr_q[0]);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    div_d   = div_q;
    ft_d    = ft_q;
    cb_d    = cb_q;
    sr_d    = sr_q;
    par_d   = par_q;
    slp_d   = slp_q;
    case (state_q)
      TX_IDLE: begin
        if (st) begin
          state_d = TX_DATA;
          half_d  = half_new;
          div_d   = half_new - DIV_W'(1);
          ft_d    = 1'b1;
          cb_d    = '0;
          sr_d    = tx_frame(ADR, DAT);
          par_d   = 1'b1;
          slp_d   = (Nvel == 2'd0);
        end
      end
      default: begin
        if (ce_tx) begin
          div_d = half_q - DIV_W'(1);
          ft_d  = ~ft_q;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
        if (bit_end) begin
          cb_d  = cb_q + 6'd1;
          sr_d  = sr_q >> 1;
          par_d = par_q ^ sdat;
          if (state_q == TX_DATA && cb_q == LAST_DAT) state_d = TX_GAP;
          if (state_q == TX_GAP && cb_q == LAST_BIT) begin
            state_d = TX_IDLE;
            cb_d    = '0;
            ft_d    = 1'b0;
            div_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      half_q  <= '0;
      div_q   <= '0;
      ft_q    <= 1'b0;
      cb_q    <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      slp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      div_q   <= div_d;
      ft_q    <= ft_d;
      cb_q    <= cb_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      slp_q   <= slp_d;
    end
  end

  assign FT_tx      = ft_q;
  assign en_tx_word = busy;
  assign en_tx_dat  = (state_q == TX_DATA);
  assign cb_bit_tx  = cb_q;
  assign SDAT       = sdat;
  assign T_cp_tx    = par_q;
  assign QM         = en_tx_dat & ft_q;
  assign TXD1       = QM & SDAT;
  assign TXD0       = QM & ~SDAT;
  assign SLP        = slp_q;

  arinc_rx u_rx (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .txd1_i   (TXD1),
    .txd0_i   (TXD0),
    .half_i   (half_q),
    .adr_o    (sr_adr_rx),
    .dat_o    (sr_dat_rx),
    .cb_o     (cb_bit_rx),
    .wr_o     (ce_wr),
    .par_ok_o (FT_cp_rx),
    .res_o    (res)
  );

endmodule

// File: tb/tb_arinc_txrx_loop.sv
// Loopback bench: random words at every rate, checked against a frame model
// built from the bit-order and parity rules, plus fault and reset cases.
`timescale 1ns/1ps
module tb_arinc_txrx_loop;

  localparam int F_CLK = 1_000_000;
  localparam int RATES [4] = '{12_500, 50_000, 100_000, 100_000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  Nvel = 2'd0;
  logic [7:0]  ADR = '0;
  logic [22:0] DAT = '0;
  logic        st = 1'b0;
  logic        ce_tx, FT_tx, en_tx_word, en_tx_dat, SDAT, T_cp_tx, QM, TXD1, TXD0, SLP;
  logic [5:0]  cb_bit_tx;
  logic [7:0]  sr_adr_rx;
  logic [22:0] sr_dat_rx;
  logic [4:0]  cb_bit_rx;
  logic        ce_wr, FT_cp_rx, res;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int res_cnt = 0;
  int both_cnt = 0;
  logic line_q = 1'b0;
  logic q_bits[$];
  logic [7:0]  last_adr = '0;
  logic [22:0] last_dat = '0;
  logic        last_ok = 1'b0;
  logic [63:0] outs;

  always #10 clk = ~clk;

  arinc_txrx_loop #(.F_CLK(F_CLK), .GAP_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .Nvel(Nvel), .ADR(ADR), .DAT(DAT), .st(st),
    .ce_tx(ce_tx), .FT_tx(FT_tx), .en_tx_word(en_tx_word), .en_tx_dat(en_tx_dat),
    .cb_bit_tx(cb_bit_tx), .SDAT(SDAT), .T_cp_tx(T_cp_tx), .QM(QM), .TXD1(TXD1),
    .TXD0(TXD0), .SLP(SLP), .sr_adr_rx(sr_adr_rx), .sr_dat_rx(sr_dat_rx),
    .cb_bit_rx(cb_bit_rx), .ce_wr(ce_wr), .FT_cp_rx(FT_cp_rx), .res(res)
  );

  assign outs = 64'({ce_tx, FT_tx, en_tx_word, en_tx_dat, cb_bit_tx, SDAT, T_cp_tx, QM,
                     TXD1, TXD0, SLP, sr_adr_rx, sr_dat_rx, cb_bit_rx, ce_wr, FT_cp_rx, res});

  always @(posedge clk) begin
    if (ce_wr) wr_cnt++;
    if (res) res_cnt++;
    if (TXD1 && TXD0) both_cnt++;
    if ((TXD1 || TXD0) && !line_q) q_bits.push_back(TXD1);
    line_q = TXD1 | TXD0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line word: ADR MSB first, DAT LSB first, then a bit making the count of ones odd.
  function automatic logic [31:0] model_frame(input logic [7:0] a, input logic [22:0] d);
    logic [31:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) f[i] = a[7-i];
    for (int i = 0; i < 23; i++) f[8+i] = d[i];
    for (int i = 0; i < 31; i++) ones += int'(f[i]);
    f[31] = (ones % 2 == 0);
    return f;
  endfunction

  // mode 0: clean word; 1: first bit forced to 0 on the line; 2: first bit's pulse removed.
  task automatic run_word(input logic [1:0] nv, input logic [7:0] a, input logic [22:0] d,
                          input int mode);
    int half, hi, guard, wr0, res0;
    logic forced;
    logic [31:0] exp_f, got_f;
    logic [7:0]  ea;
    logic [22:0] ed;
    logic        eok;
    half  = F_CLK / (2 * RATES[nv]);
    exp_f = model_frame(a, d);
    q_bits.delete();
    wr0 = wr_cnt;
    res0 = res_cnt;
    Nvel = nv; ADR = a; DAT = d; st = 1'b1;
    forced = (mode != 0);
    if (mode == 1) force dut.SDAT = 1'b0;
    if (mode == 2) force dut.TXD1 = 1'b0;
    @(negedge clk);
    st = 1'b0;
    chk("start", 64'(en_tx_word), 64'd1);
    hi = 1;
    guard = 0;
    while (en_tx_word && guard < 80 * half) begin
      @(negedge clk);
      guard++;
      if (en_tx_word) hi++;
      if (forced && cb_bit_tx != 6'd0) begin
        if (mode == 1) release dut.SDAT;
        else release dut.TXD1;
        forced = 1'b0;
      end
      if (hi == 50) begin
        chk("slp", 64'(SLP), 64'(nv == 2'd0));
        ADR = ~a; DAT = ~d; st = 1'b1;
      end else if (hi == 51) begin
        st = 1'b0;
      end
    end
    chk("word_len", 64'(hi), 64'(72 * half));
    got_f = '0;
    if (mode == 0) begin
      chk("line_bits", 64'(q_bits.size()), 64'd32);
      if (q_bits.size() == 32) begin
        for (int i = 0; i < 32; i++) got_f[i] = q_bits[i];
        chk("line_frame", 64'(got_f), 64'(exp_f));
      end
    end
    ea = a; ed = d; eok = 1'b1;
    if (mode == 1) begin
      ea = a & 8'h7F;
      eok = 1'b0;
    end else if (mode == 2) begin
      ea = last_adr; ed = last_dat; eok = last_ok;
    end
    chk("ce_wr_n", 64'(wr_cnt - wr0), (mode == 2) ? 64'd0 : 64'd1);
    chk("res_n", 64'(res_cnt - res0), (mode == 2) ? 64'd1 : 64'd0);
    chk("rx_adr", 64'(sr_adr_rx), 64'(ea));
    chk("rx_dat", 64'(sr_dat_rx), 64'(ed));
    chk("rx_par", 64'(FT_cp_rx), 64'(eok));
    last_adr = ea; last_dat = ed; last_ok = eok;
  endtask

  initial begin
    int w0, r0;
    repeat (5) @(negedge clk);
    chk("rst_outs", outs, 64'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_outs", outs, 64'd0);
    chk("idle_ce_wr", 64'(wr_cnt), 64'd0);

    run_word(2'd1, 8'hFF, 23'h111111, 0);
    run_word(2'd1, 8'h82, 23'h567800, 0);
    run_word(2'd0, 8'($urandom), 23'($urandom), 0);
    run_word(2'd2, 8'($urandom), 23'($urandom), 0);
    for (int i = 0; i < 6; i++)
      run_word(2'($urandom_range(1, 3)), 8'($urandom), 23'($urandom), 0);
    run_word(2'd1, 8'($urandom) | 8'h80, 23'($urandom), 1);
    run_word(2'd2, 8'($urandom) | 8'h80, 23'($urandom), 2);
    run_word(2'd1, 8'($urandom), 23'($urandom), 0);

    // Reset in the middle of a word.
    Nvel = 2'd1; ADR = 8'($urandom); DAT = 23'($urandom); st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (300) @(negedge clk);
    w0 = wr_cnt;
    r0 = res_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_txd", 64'({TXD1, TXD0}), 64'd0);
    chk("rst_busy", 64'(en_tx_word), 64'd0);
    chk("rst_cb_rx", 64'(cb_bit_rx), 64'd0);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("rst_no_wr", 64'(wr_cnt - w0), 64'd0);
    chk("rst_no_res", 64'(res_cnt - r0), 64'd0);
    chk("rst_idle_outs", outs, 64'd0);
    run_word(2'd3, 8'($urandom), 23'($urandom), 0);

    chk("never_both", 64'(both_cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
